// File: rtl/mmu_async_pkg.sv
// Shared types and constants for the MMU synchronous/asynchronous boundary blocks.
package mmu_async_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT_FREE
  } launch_state_t;

  localparam int unsigned TOK_CNT_W = 16;

endpackage

// File: rtl/mmu_sync_first_fifo_sync.sv
// Generic flop-chain synchronizer for a single asynchronous level or phase signal.
module sync_ff_mmu #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/mmu_sync_first_fifo.sv
// Clocked-to-asynchronous launch stage: buffers words in a FIFO and launches them one at a
// time as bundled data with a 2-phase drive/free handshake.
module mmu_sync_first_fifo
  import mmu_async_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SETUP       = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DW-1:0]        s_data,
  output logic                 o_drive,
  output logic [DW-1:0]        o_data,
  input  logic                 i_free,
  output logic                 o_busy,
  output logic                 o_err,
  output logic [TOK_CNT_W-1:0] o_tok_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] SETUP_LAST = 4'(SETUP - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop, launch;
  logic          free_s, free_last, free_evt;
  logic [3:0]    setup_cnt;
  launch_state_t state, state_nxt;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign s_ready = !full;
  assign push    = s_valid && !full;
  assign o_busy  = (state != ST_IDLE) || !empty;

  sync_ff_mmu #(.SYNC_STAGES(SYNC_STAGES)) u_free_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_free),
    .q   (free_s)
  );

  assign free_evt = free_s ^ free_last;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    launch    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (setup_cnt == SETUP_LAST) begin
          launch    = 1'b1;
          state_nxt = ST_WAIT_FREE;
        end
      end
      ST_WAIT_FREE: begin
        if (free_evt) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_data    <= '0;
      setup_cnt <= '0;
      o_drive   <= 1'b0;
      o_tok_cnt <= '0;
      o_err     <= 1'b0;
      free_last <= 1'b0;
    end else begin
      free_last <= free_s;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        o_data    <= mem[rd_ptr[AW-1:0]];
        rd_ptr    <= rd_ptr + 1'b1;
        setup_cnt <= '0;
      end else if (state == ST_SETUP) begin
        setup_cnt <= setup_cnt + 1'b1;
      end
      if (launch) begin
        o_drive   <= ~o_drive;
        o_tok_cnt <= o_tok_cnt + 1'b1;
      end
      // A free with no token outstanding is flagged but never advances the FSM.
      if (free_evt && (state != ST_WAIT_FREE)) o_err <= 1'b1;
    end
  end

endmodule
